// File: rtl/ensemble_vote.sv
// ensemble_vote: 2-of-3 majority vote over three AXI-Stream classifier results.
// Optional stat counters when ENSEMBLE_VOTE_STATS_EN is defined.
module ensemble_vote #(
    parameter int DATA_WIDTH  = 32,
    parameter int KEEP_WIDTH  = 4,
    parameter int CLASS_WIDTH = 8,
    parameter int TIE_SEL     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_1,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_1,
    input  logic                  s_axis_tvalid_1,
    output logic                  s_axis_tready_1,
    input  logic                  s_axis_tlast_1,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_2,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_2,
    input  logic                  s_axis_tvalid_2,
    output logic                  s_axis_tready_2,
    input  logic                  s_axis_tlast_2,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_3,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_3,
    input  logic                  s_axis_tvalid_3,
    output logic                  s_axis_tready_3,
    input  logic                  s_axis_tlast_3,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
`ifdef ENSEMBLE_VOTE_STATS_EN
    ,
    output logic [15:0]           stat_votes,
    output logic [15:0]           stat_unanimous,
    output logic [15:0]           stat_ties
`endif
);

    localparam logic [1:0] TS = 2'(TIE_SEL);

    typedef enum logic {COLLECT, EMIT} state_e;

    state_e                 state_q, state_d;
    logic                   rdy_q, rdy_d;
    logic [2:0]             full_q, full_d;
    logic [2:0]             last_q, last_d;
    logic [CLASS_WIDTH-1:0] lbl_q [3];
    logic [CLASS_WIDTH-1:0] lbl_d [3];
    logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
    logic                   tlast_q, tlast_d;
    logic                   tvalid_q, tvalid_d;

    logic [CLASS_WIDTH-1:0] in_lbl [3];
    logic [2:0]             in_vld, in_last, in_rdy, hs;
    logic [CLASS_WIDTH-1:0] dec_lbl;
    logic [1:0]             agree;
    logic [DATA_WIDTH-1:0]  word;
    logic                   unused_bits;

    assign in_lbl[0] = s_axis_tdata_1[CLASS_WIDTH-1:0];
    assign in_lbl[1] = s_axis_tdata_2[CLASS_WIDTH-1:0];
    assign in_lbl[2] = s_axis_tdata_3[CLASS_WIDTH-1:0];
    assign in_vld    = {s_axis_tvalid_3, s_axis_tvalid_2, s_axis_tvalid_1};
    assign in_last   = {s_axis_tlast_3, s_axis_tlast_2, s_axis_tlast_1};
    assign in_rdy    = {3{rdy_q}} & ~full_q;
    assign hs        = in_vld & in_rdy;

    // tkeep and label-extraneous tdata bits carry no meaning here
    assign unused_bits = ^{s_axis_tdata_1, s_axis_tdata_2, s_axis_tdata_3,
                           s_axis_tkeep_1, s_axis_tkeep_2, s_axis_tkeep_3};

    assign s_axis_tready_1 = in_rdy[0];
    assign s_axis_tready_2 = in_rdy[1];
    assign s_axis_tready_3 = in_rdy[2];
    assign m_axis_tdata    = tdata_q;
    assign m_axis_tlast    = tlast_q;
    assign m_axis_tvalid   = tvalid_q;
    assign m_axis_tkeep    = '1;

    // slot capture: fill each free slot on its input handshake
    always_comb begin
        rdy_d  = 1'b1;
        full_d = full_q;
        last_d = last_q;
        lbl_d  = lbl_q;
        for (int i = 0; i < 3; i++) begin
            if (hs[i]) begin
                full_d[i] = 1'b1;
                last_d[i] = in_last[i];
                lbl_d[i]  = in_lbl[i];
            end
        end
    end

    // vote on the slot contents as they will stand after this edge
    always_comb begin
        dec_lbl = lbl_d[TS];
        agree   = 2'd1;
        if (lbl_d[0] == lbl_d[1] && lbl_d[1] == lbl_d[2]) begin
            dec_lbl = lbl_d[0];
            agree   = 2'd3;
        end else if (lbl_d[0] == lbl_d[1] || lbl_d[0] == lbl_d[2]) begin
            dec_lbl = lbl_d[0];
            agree   = 2'd2;
        end else if (lbl_d[1] == lbl_d[2]) begin
            dec_lbl = lbl_d[1];
            agree   = 2'd2;
        end
        word                    = '0;
        word[CLASS_WIDTH-1:0]   = dec_lbl;
        word[CLASS_WIDTH+:2]    = agree;
        word[CLASS_WIDTH+2]     = (|last_d) & ~(&last_d);
    end

    // FSM: latch the decision once all slots are full, release on handshake
    always_comb begin
        state_d  = state_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q;
        unique case (state_q)
            COLLECT: begin
                if (&full_d) begin
                    state_d  = EMIT;
                    tdata_d  = word;
                    tlast_d  = &last_d;
                    tvalid_d = 1'b1;
                end
            end
            EMIT: begin
                if (m_axis_tready) begin
                    state_d  = COLLECT;
                    tvalid_d = 1'b0;
                end
            end
        endcase
    end

    // state registers; slots clear on the output handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= COLLECT;
            rdy_q    <= 1'b0;
            full_q   <= '0;
            last_q   <= '0;
            lbl_q    <= '{default: '0};
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_q    <= rdy_d;
            full_q   <= (state_q == EMIT && m_axis_tready) ? 3'b000 : full_d;
            last_q   <= last_d;
            lbl_q    <= lbl_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
        end
    end

`ifdef ENSEMBLE_VOTE_STATS_EN
    logic [15:0] votes_q, votes_d;
    logic [15:0] unan_q, unan_d;
    logic [15:0] ties_q, ties_d;
    logic        out_hs;
    logic [1:0]  out_agree;

    assign out_hs    = tvalid_q & m_axis_tready;
    assign out_agree = tdata_q[CLASS_WIDTH+:2];

    // count emitted votes by agreement level
    always_comb begin
        votes_d = votes_q;
        unan_d  = unan_q;
        ties_d  = ties_q;
        if (out_hs) begin
            votes_d = votes_q + 16'd1;
            if (out_agree == 2'd3) unan_d = unan_q + 16'd1;
            if (out_agree == 2'd1) ties_d = ties_q + 16'd1;
        end
    end

    // stat counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            votes_q <= '0;
            unan_q  <= '0;
            ties_q  <= '0;
        end else begin
            votes_q <= votes_d;
            unan_q  <= unan_d;
            ties_q  <= ties_d;
        end
    end

    assign stat_votes     = votes_q;
    assign stat_unanimous = unan_q;
    assign stat_ties      = ties_q;
`endif

endmodule
